// File: rtl/ram_pkg.sv
// Shared definitions for the ram_2r1w storage primitive: clear-sequencer
// state encoding and default geometry.
package ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } ram_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 64;

endpackage

// File: rtl/ram_init_seq.sv
// Clear sequencer: owns the array while sweeping zeros through every word
// after reset or on a clear request, then hands the write port back.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic          swe,
  output logic [AW-1:0] swa
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  ram_state_t    state, state_n;
  logic [AW-1:0] cnt, cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // A clear while already sweeping restarts the sweep rather than queueing.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      INIT: begin
        if (clr) begin
          cnt_n = '0;
        end else if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          state_n = INIT;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = INIT;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy = (state == INIT);
  assign swe  = busy;
  assign swa  = cnt;

endmodule

// File: rtl/ram_2r1w.sv
// Parametrised RAM with one synchronous write port, two registered read
// ports with write-first bypass, and a built-in zero-fill sequencer.
module ram_2r1w
  import ram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic             busy,
  output logic             wdrop
);

  // One extra bit so DEPTH itself is representable when it is a power of two.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             swe;
  logic [AW-1:0]    swa;
  logic             wa_ok, ra1_ok, ra2_ok, wr_ok, mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd, q1_n, q2_n;

  ram_init_seq #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_init_seq (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .busy(busy),
    .swe (swe),
    .swa (swa)
  );

  assign wa_ok  = ({1'b0, wa} < DEPTH_W);
  assign ra1_ok = ({1'b0, ra1} < DEPTH_W);
  assign ra2_ok = ({1'b0, ra2} < DEPTH_W);
  assign wr_ok  = !busy && we && !clr && wa_ok;

  assign mem_we = swe || wr_ok;
  assign mem_wa = swe ? swa : wa;
  assign mem_wd = swe ? '0 : d;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Out-of-range and in-sweep reads return zero; a same-cycle accepted write wins.
  always_comb begin
    q1_n = '0;
    q2_n = '0;
    if (!busy && ra1_ok) begin
      q1_n = (wr_ok && (wa == ra1)) ? d : mem[ra1];
    end
    if (!busy && ra2_ok) begin
      q2_n = (wr_ok && (wa == ra2)) ? d : mem[ra2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1    <= '0;
      q2    <= '0;
      wdrop <= 1'b0;
    end else begin
      q1    <= q1_n;
      q2    <= q2_n;
      wdrop <= we && !wr_ok;
    end
  end

endmodule

// File: tb/tb_ram_2r1w.sv
// Self-checking bench for ram_2r1w: a 64x8 and a 40x16 instance driven side by
// side and compared every cycle against a word-array reference model.
module tb_ram_2r1w;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_clr, a_we;
  logic [5:0]  a_wa, a_ra1, a_ra2;
  logic [7:0]  a_d, a_q1, a_q2;
  logic        a_busy, a_wdrop;

  logic        b_clr, b_we;
  logic [5:0]  b_wa, b_ra1, b_ra2;
  logic [15:0] b_d, b_q1, b_q2;
  logic        b_busy, b_wdrop;

  int n_cmp = 0;
  int n_err = 0;

  int          dep [2] = '{64, 40};
  logic [15:0] msk [2] = '{16'h00FF, 16'hFFFF};
  logic [15:0] mm  [2][64];
  int          left [2];
  logic [15:0] eq1 [2], eq2 [2];
  logic        ewd [2];

  always #5 clk = ~clk;

  ram_2r1w #(.WIDTH(8), .DEPTH(64)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .we(a_we), .wa(a_wa), .d(a_d),
    .ra1(a_ra1), .ra2(a_ra2), .q1(a_q1), .q2(a_q2), .busy(a_busy), .wdrop(a_wdrop)
  );

  ram_2r1w #(.WIDTH(16), .DEPTH(40)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .we(b_we), .wa(b_wa), .d(b_d),
    .ra1(b_ra1), .ra2(b_ra2), .q1(b_q1), .q2(b_q2), .busy(b_busy), .wdrop(b_wdrop)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      left[k] = dep[k];
      eq1[k]  = '0;
      eq2[k]  = '0;
      ewd[k]  = 1'b0;
      for (int i = 0; i < 64; i++) mm[k][i] = '0;
    end
  endtask

  // Array contents are unobservable while sweeping, so a clear zeroes the model at once.
  task automatic model_edge(int k, logic c, logic w, logic [5:0] wa, logic [15:0] dd,
                            logic [5:0] r1, logic [5:0] r2);
    bit bz, acc;
    bz  = (left[k] > 0);
    acc = !bz && w && !c && (int'(wa) < dep[k]);
    eq1[k] = (bz || int'(r1) >= dep[k]) ? 16'h0 : (acc && wa == r1) ? (dd & msk[k]) : mm[k][r1];
    eq2[k] = (bz || int'(r2) >= dep[k]) ? 16'h0 : (acc && wa == r2) ? (dd & msk[k]) : mm[k][r2];
    ewd[k] = w && !acc;
    if (acc) mm[k][wa] = dd & msk[k];
    if (c) begin
      left[k] = dep[k];
      for (int i = 0; i < 64; i++) mm[k][i] = '0;
    end else if (bz) begin
      left[k] = left[k] - 1;
    end
  endtask

  task automatic set_idle();
    a_clr = 0; a_we = 0; a_wa = 0; a_d = 0; a_ra1 = 0; a_ra2 = 0;
    b_clr = 0; b_we = 0; b_wa = 0; b_d = 0; b_ra1 = 0; b_ra2 = 0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    model_edge(0, a_clr, a_we, a_wa, {8'h00, a_d}, a_ra1, a_ra2);
    model_edge(1, b_clr, b_we, b_wa, b_d, b_ra1, b_ra2);
    @(negedge clk);
  endtask

  task automatic cmp(string tag, logic [15:0] obs, logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    cmp({tag, "/a.q1"},    {8'h00, a_q1},    eq1[0]);
    cmp({tag, "/a.q2"},    {8'h00, a_q2},    eq2[0]);
    cmp({tag, "/a.busy"},  {15'h0, a_busy},  {15'h0, left[0] > 0});
    cmp({tag, "/a.wdrop"}, {15'h0, a_wdrop}, {15'h0, ewd[0]});
    cmp({tag, "/b.q1"},    b_q1,             eq1[1]);
    cmp({tag, "/b.q2"},    b_q2,             eq2[1]);
    cmp({tag, "/b.busy"},  {15'h0, b_busy},  {15'h0, left[1] > 0});
    cmp({tag, "/b.wdrop"}, {15'h0, b_wdrop}, {15'h0, ewd[1]});
  endtask

  task automatic step(string tag);
    applyStimulus();
    checkOutput(tag);
  endtask

  initial begin
    // Power-on reset and the initial sweep, busy checked on every edge.
    rst = 1'b1;
    set_idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset");
    rst = 1'b0;
    for (int i = 0; i < 66; i++) step("sweep");

    a_ra1 = 0; a_ra2 = 12;
    step("read_0_12");
    a_ra1 = 63;
    step("read_63");

    // Directed writes on A; out-of-range and top-word writes on B.
    a_we = 1; a_wa = 2;  a_d = 100;
    b_we = 1; b_wa = 45; b_d = 16'h1234;
    step("wr_2");
    a_wa = 12; a_d = 30;
    b_wa = 39; b_d = 16'hBEEF;
    step("wr_12");
    a_wa = 3; a_d = 48;
    b_we = 0; b_ra1 = 45; b_ra2 = 39;
    step("wr_3");
    a_we = 0; a_ra1 = 2; a_ra2 = 3;
    step("rd_2_3");
    a_ra1 = 1; a_ra2 = 12;
    step("rd_1_12");

    a_we = 1; a_wa = 5; a_d = 8'hA5; a_ra1 = 5; a_ra2 = 5;
    step("bypass");
    a_we = 0;
    step("bypass_hold");

    // Clear colliding with a write, then a write attempted mid-sweep.
    a_clr = 1; a_we = 1; a_wa = 9; a_d = 77;
    step("clr_we");
    a_clr = 0; a_wa = 7; a_d = 9;
    step("we_busy");
    a_we = 0;
    for (int i = 0; i < 64; i++) step("clr_sweep");
    a_ra1 = 7; a_ra2 = 2;
    step("rd_after_clr");

    for (int i = 0; i < 400; i++) begin
      a_clr = ($urandom_range(49) == 0); a_we = $urandom_range(1);
      a_wa  = 6'($urandom_range(63));    a_d  = 8'($urandom);
      a_ra1 = 6'($urandom_range(63));    a_ra2 = 6'($urandom_range(63));
      b_clr = ($urandom_range(49) == 0); b_we = $urandom_range(1);
      b_wa  = 6'($urandom_range(63));    b_d  = 16'($urandom);
      b_ra1 = 6'($urandom_range(63));    b_ra2 = 6'($urandom_range(63));
      step("rand");
    end

    set_idle();
    for (int i = 0; i < 66; i++) step("settle");
    a_we = 1; a_wa = 1; a_d = 8'h3C;
    b_we = 1; b_wa = 2; b_d = 16'hFFFF;
    step("pre_rst_wr");
    a_we = 0; a_ra1 = 1; a_ra2 = 1;
    b_we = 0; b_ra1 = 2; b_ra2 = 2;
    step("pre_rst_rd");

    // Asynchronous reset mid-operation, then again partway through the sweep.
    #2 rst = 1'b1;
    #1 model_reset();
    checkOutput("async_rst_op");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) step("part_sweep");
    #2 rst = 1'b1;
    #1 model_reset();
    checkOutput("async_rst_sweep");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 66; i++) step("resweep");
    a_ra1 = 1; b_ra1 = 2;
    step("rd_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_2r1w.md
# ram_2r1w

Parametrised successor to the single-port scratch RAM: one synchronous write port, two independent registered read ports, same-cycle write-to-read bypass, and a built-in clear sequencer that zero-fills the array after reset or on request. It sits in the util library as the common storage primitive for register files and small buffers, replacing fixed 8-bit × 64 instances.

## Interface
- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 64, number of words (≥2, need not be a power of two)
- `AW`, $clog2(DEPTH), address width (derived; do not override)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `clr`  in  1  request zero-fill of the whole array
- `we`  in  1  write enable
- `wa`  in  AW  write address
- `d`  in  WIDTH  write data
- `ra1`  in  AW  read address, port 1
- `ra2`  in  AW  read address, port 2
- `q1`  out  WIDTH  registered read data, port 1
- `q2`  out  WIDTH  registered read data, port 2
- `busy`  out  1  high while the clear sequencer owns the array
- `wdrop`  out  1  one-cycle pulse: a write request was discarded

## Operation
- FSM states: INIT (sweeping), IDLE (normal). Reset forces INIT with sweep counter = 0.
- INIT: each cycle writes 0 to mem[counter], counter++; at counter == DEPTH-1 the write completes and the next state is IDLE. Sweep takes exactly DEPTH cycles.
- `clr` in IDLE: next state INIT, counter = 0. `clr` in INIT: counter restarts at 0 (sweep extends).
- `busy` = (state == INIT), combinational from state.
- Write: in IDLE, `we` with `wa` < DEPTH writes `d` to mem[wa] at the edge. `clr` and `we` in the same IDLE cycle: write is discarded, sweep starts.
- `wdrop` pulses (registered, next cycle) when `we`=1 and the write is discarded: state INIT, simultaneous `clr`, or `wa` ≥ DEPTH.
- Read: each port registers independently. Next value of `qN`: 0 if busy or `raN` ≥ DEPTH; else `d` if an accepted write targets `raN` this cycle (write-first bypass); else mem[raN]. Both ports may read the same address.
- Reset values: `q1` = `q2` = 0, `wdrop` = 0, `busy` = 1. Array contents are not reset directly; the sweep clears them.

## Timing
- Write latency 1: data written at edge k readable at `qN` after edge k (bypass) or any later read.
- Read latency 1: `raN` sampled at edge k, `qN` valid after edge k, held until next edge.
- After `rst` falls, `busy` stays high for exactly DEPTH rising edges, then drops; first accepted write is at the edge where `busy` was sampled low.
- Reset asserted mid-sweep or mid-operation: outputs go to reset values immediately (async), sweep restarts from 0 on release.
- Address wrap: none; counter never exceeds DEPTH-1; out-of-range addresses never alias.

## Structure
- Shared package `ram_pkg`: FSM state encoding (INIT, IDLE), default WIDTH/DEPTH constants.
- One sub-module: `ram_init_seq` (state register, sweep counter, `busy`, sweep write address/enable); the top muxes its write port over the user port and owns the array and read registers.

## Test plan
- Reset release, DEPTH=64: `busy` high for exactly 64 edges; reading addresses 0, 12, 63 afterwards returns 0.
- Writes 100→2, 30→12, 48→3 in IDLE; then `ra1`=2, `ra2`=3 → q1=100, q2=48 one edge later; `ra1`=1 → 0; `ra2`=12 → 30.
- Bypass: `we`=1, `wa`=5, `d`=0xA5, `ra1`=`ra2`=5 in the same cycle → q1=q2=0xA5 next edge.
- Write during sweep (`we`=1, `wa`=7, `d`=9 while busy) → `wdrop` pulses once, mem[7] reads 0 after sweep; `clr`+`we` same cycle → `wdrop` pulse, `busy` rises next edge.
- Reset asserted at sweep counter 30 → q1/q2 = 0 immediately, `busy`=1, full 64-cycle sweep follows release.
- DEPTH=40, WIDTH=16: write `wa`=45 → `wdrop`; read `ra1`=45 → q1=0; write 0xBEEF→39 reads back 0xBEEF.
